vregfile_sb: RTL

Parametrised vector register file, the successor to the fixed 4x4x32 vector file. It serves the vector pipeline's decode/read stage and writeback stage. Additions over the fixed version:
- configurable lane count, width and depth
- per-lane write mask
- optional write-to-read bypass
- sequenced zero-initialisation FSM
- busy scoreboard for in-flight destinations

---
 rtl/vregfile_sb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vregfile_sb.sv
// vregfile_sb: parametrised vector register file for the vector pipeline.
// Per-lane masked writes, optional write-to-read forwarding, a sequenced
// zero-initialisation FSM (INIT/RUN) and a busy scoreboard for pending
// destinations. Out-of-range register indices are treated as absent.
module vregfile_sb #(
  parameter int LANES  = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 16,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  wren,
  input  logic [AW-1:0]         wraddr,
  input  logic [LANES-1:0]      wrmask,
  input  logic [LANES*DW-1:0]   wrdata,
  input  logic [AW-1:0]         readAddr1,
  input  logic [AW-1:0]         readAddr2,
  output logic [LANES*DW-1:0]   r1v,
  output logic [LANES*DW-1:0]   r2v,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  r1busy,
  output logic                  r2busy,
  output logic                  rsv_err
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Index bound widened by one bit so DEPTH itself is representable.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH-1);
  localparam logic [AW-1:0] ONE_W   = AW'(1'b1);

  state_t               state_r, state_s;
  logic [AW-1:0]        cnt_r, cnt_s;
  logic [DEPTH-1:0]     busy_r, busy_s;
  logic                 rsv_err_r, rsv_err_s;
  logic [LANES*DW-1:0]  mem_r [DEPTH];

  logic run_s, wr_ok_s, rsv_ok_s, rd1_ok_s, rd2_ok_s, byp1_s, byp2_s;

  // Qualify requests: only honoured in RUN, with an in-range index, and not under clr.
  always_comb begin
    run_s    = (state_r == ST_RUN);
    wr_ok_s  = run_s & ~clr & wren   & ({1'b0, wraddr}    < DEPTH_W);
    rsv_ok_s = run_s & ~clr & rsv_en & ({1'b0, rsv_addr}  < DEPTH_W);
    rd1_ok_s = ({1'b0, readAddr1} < DEPTH_W);
    rd2_ok_s = ({1'b0, readAddr2} < DEPTH_W);
    byp1_s   = BYPASS & wren & run_s & (wraddr == readAddr1);
    byp2_s   = BYPASS & wren & run_s & (wraddr == readAddr2);
  end

  // FSM state register and init counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // FSM next state: walk every register once in INIT, leave RUN on clr.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_W) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else begin
          state_s = ST_INIT;
          cnt_s   = cnt_r + ONE_W;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_s = ST_INIT;
          cnt_s   = '0;
        end else begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = '0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready   = (state_r == ST_RUN);
    rsv_err = rsv_err_r;
  end

  // Storage: INIT zeroes one register per cycle; RUN applies lane-masked writes.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= '0;
    end else if (wr_ok_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (wrmask[i]) begin
          mem_r[wraddr][i*DW +: DW] <= wrdata[i*DW +: DW];
        end
      end
    end
  end

  // Scoreboard next state: reservation set beats writeback clear; flag double reservation.
  always_comb begin
    busy_s    = '0;
    rsv_err_s = 1'b0;
    if (!run_s || clr) begin
      busy_s    = '0;
      rsv_err_s = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_s[i] = (rsv_ok_s & (rsv_addr == AW'(i))) |
                    (busy_r[i] & ~(wr_ok_s & (wraddr == AW'(i))));
      end
      rsv_err_s = rsv_ok_s & busy_r[rsv_addr] & ~(wr_ok_s & (wraddr == rsv_addr));
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= '0;
      rsv_err_r <= 1'b0;
    end else begin
      busy_r    <= busy_s;
      rsv_err_r <= rsv_err_s;
    end
  end

  // Read ports: zero during INIT or for absent registers, else stored data with per-lane forwarding.
  always_comb begin
    r1v    = '0;
    r2v    = '0;
    r1busy = 1'b0;
    r2busy = 1'b0;
    if (run_s && rd1_ok_s) begin
      r1busy = busy_r[readAddr1];
      for (int i = 0; i < LANES; i++) begin
        r1v[i*DW +: DW] = (byp1_s && wrmask[i]) ? wrdata[i*DW +: DW] : mem_r[readAddr1][i*DW +: DW];
      end
    end else begin
      r1v    = '0;
      r1busy = 1'b0;
    end
    if (run_s && rd2_ok_s) begin
      r2busy = busy_r[readAddr2];
      for (int i = 0; i < LANES; i++) begin
        r2v[i*DW +: DW] = (byp2_s && wrmask[i]) ? wrdata[i*DW +: DW] : mem_r[readAddr2][i*DW +: DW];
      end
    end else begin
      r2v    = '0;
      r2busy = 1'b0;
    end
  end

endmodule
